// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for mem_port_arbiter: flattened request lanes in, grant/response out, one memory port.
// No logic or latency; the slave modport is the arbiter, the master modport is the surrounding clients plus memory.
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic                    busy;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [STRB_W-1:0]       mem_wstrb;
  logic                    mem_ready;
  logic                    mem_rsp_valid;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    err_stray;

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_wstrb, mem_ready, mem_rsp_valid, mem_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err, busy, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wstrb, err_stray
  );

  modport master (
    output req, req_we, req_addr, req_wdata, req_wstrb, mem_ready, mem_rsp_valid, mem_rdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, busy, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wstrb, err_stray
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter onto one memory port, one transaction in flight; grant 1 cycle after req, rsp 1 cycle after mem rsp.
// Requests wait while busy; mem_req is held until mem_ready; a silent memory is cut off by the timeout counter.
module mem_port_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mem_port_arbiter_if.slave    bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [TO_W-1:0]     r_cnt;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_rsp_vld;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic                r_err_stray;

  logic                w_any;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_cand;
  logic [IDX_W-1:0]    w_next_ptr;

  // Scan candidates in priority order; round-robin starts the scan at r_ptr and wraps.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (RR_MODE != 0) begin
        if (int'(r_ptr) + k >= N_REQ) w_cand = IDX_W'(int'(r_ptr) + k - N_REQ);
        else                          w_cand = IDX_W'(int'(r_ptr) + k);
      end else begin
        w_cand = IDX_W'(k);
      end
      if (!w_any && bus.req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_next_ptr = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + IDX_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_vld   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      if (bus.mem_rsp_valid && r_state != WAIT) r_err_stray <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_win;
            r_ptr       <= w_next_ptr;
            r_gnt       <= N_REQ'(1) << w_win;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.req_we[w_win];
            r_mem_addr  <= bus.req_addr[w_win*ADDR_W +: ADDR_W];
            r_mem_wdata <= bus.req_wdata[w_win*DATA_W +: DATA_W];
            r_mem_wstrb <= bus.req_wstrb[w_win*STRB_W +: STRB_W];
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          // A real response beats the timeout when both land on the same cycle.
          if (bus.mem_rsp_valid) begin
            r_rsp_rdata <= bus.mem_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_vld   <= N_REQ'(1) << r_owner;
            r_state     <= RESP;
          end else if (r_cnt == TO_W'(TIMEOUT)) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_vld   <= N_REQ'(1) << r_owner;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        RESP: begin
          r_rsp_err <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.err_stray = r_err_stray;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 3-requester round-robin instance and a 2-requester fixed-priority instance share stimulus.
// A per-cycle reference model is compared on every falling edge; directed tests add hand-computed expectations.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req_m = '0;
  logic [2:0]  we_m  = '0;
  logic [63:0] addr  [3];
  logic [63:0] wdata [3];
  logic [7:0]  wstrb [3];
  logic        mready = 1'b0;
  logic        mrv    = 1'b0;
  logic [63:0] mrdata = '0;

  int checks = 0;
  int errors = 0;
  int mreq_cnt = 0;

  mem_port_arbiter_if #(.N_REQ(3), .ADDR_W(64), .DATA_W(64)) ifa ();
  mem_port_arbiter_if #(.N_REQ(2), .ADDR_W(64), .DATA_W(64)) ifb ();

  assign ifa.req           = req_m;
  assign ifa.req_we        = we_m;
  assign ifa.req_addr      = {addr[2], addr[1], addr[0]};
  assign ifa.req_wdata     = {wdata[2], wdata[1], wdata[0]};
  assign ifa.req_wstrb     = {wstrb[2], wstrb[1], wstrb[0]};
  assign ifa.mem_ready     = mready;
  assign ifa.mem_rsp_valid = mrv;
  assign ifa.mem_rdata     = mrdata;
  assign ifb.req           = req_m[1:0];
  assign ifb.req_we        = we_m[1:0];
  assign ifb.req_addr      = {addr[1], addr[0]};
  assign ifb.req_wdata     = {wdata[1], wdata[0]};
  assign ifb.req_wstrb     = {wstrb[1], wstrb[0]};
  assign ifb.mem_ready     = mready;
  assign ifb.mem_rsp_valid = mrv;
  assign ifb.mem_rdata     = mrdata;

  mem_port_arbiter #(.N_REQ(3), .ADDR_W(64), .DATA_W(64), .RR_MODE(1), .TIMEOUT(4))
    u_rr (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  mem_port_arbiter #(.N_REQ(2), .ADDR_W(64), .DATA_W(64), .RR_MODE(0), .TIMEOUT(4))
    u_fp (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  // ---------------- reference model (index 0 = round-robin instance, 1 = fixed priority) ----------------
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_RESP = 3;
  int          ph [2];
  int          own[2];
  int          ptr[2];
  int          wc [2];
  logic [2:0]  e_gnt[2], e_rsp[2];
  logic [63:0] e_rd[2], e_addr[2], e_wd[2];
  logic [7:0]  e_ws[2];
  logic        e_err[2], e_mreq[2], e_we[2], e_stray[2];

  function automatic int pick(input int m, input int n, input bit rr, input int p);
    for (int k = 0; k < n; k++) begin
      int i;
      i = rr ? (p + k) % n : k;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w, n, m;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] <= PH_IDLE; own[d] <= 0; ptr[d] <= 0; wc[d] <= 0;
        e_gnt[d] <= '0; e_rsp[d] <= '0; e_rd[d] <= '0; e_err[d] <= 1'b0;
        e_mreq[d] <= 1'b0; e_we[d] <= 1'b0; e_addr[d] <= '0; e_wd[d] <= '0;
        e_ws[d] <= '0; e_stray[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? 3 : 2;
        m = (d == 0) ? int'(req_m) : int'(req_m[1:0]);
        e_gnt[d] <= '0;
        e_rsp[d] <= '0;
        if (mrv && ph[d] != PH_WAIT) e_stray[d] <= 1'b1;
        if (ph[d] == PH_IDLE && m != 0) begin
          w = pick(m, n, (d == 0), ptr[d]);
          own[d]   <= w;
          ptr[d]   <= (w + 1) % n;
          e_gnt[d] <= 3'(1 << w);
          e_mreq[d] <= 1'b1;
          e_we[d]  <= we_m[w];
          e_addr[d] <= addr[w];
          e_wd[d]  <= wdata[w];
          e_ws[d]  <= wstrb[w];
          ph[d]    <= PH_ISSUE;
        end else if (ph[d] == PH_ISSUE && mready) begin
          e_mreq[d] <= 1'b0;
          wc[d]    <= 0;
          ph[d]    <= PH_WAIT;
        end else if (ph[d] == PH_WAIT) begin
          if (mrv || wc[d] == 4) begin
            e_rd[d]  <= mrv ? mrdata : 64'h0;
            e_err[d] <= !mrv;
            e_rsp[d] <= 3'(1 << own[d]);
            ph[d]    <= PH_RESP;
          end else begin
            wc[d] <= wc[d] + 1;
          end
        end else if (ph[d] == PH_RESP) begin
          e_err[d] <= 1'b0;
          ph[d]    <= PH_IDLE;
        end
      end
    end
  end

  task automatic cmp(input int d, input logic [2:0] g, input logic [2:0] r, input logic [63:0] rd,
                     input logic er, input logic bs, input logic mq, input logic mw,
                     input logic [63:0] ma, input logic [63:0] mwd, input logic [7:0] ms, input logic st);
    logic bs_e;
    bs_e = (ph[d] != PH_IDLE);
    checks++;
    if ({g, r, rd, er, bs, mq, mw, ma, mwd, ms, st} !==
        {e_gnt[d], e_rsp[d], e_rd[d], e_err[d], bs_e, e_mreq[d], e_we[d], e_addr[d], e_wd[d], e_ws[d], e_stray[d]}) begin
      errors++;
      $display("FAIL model_dut%0d t=%0t got gnt=%b rsp=%b rd=%h err=%b busy=%b mreq=%b we=%b addr=%h wd=%h ws=%h stray=%b required gnt=%b rsp=%b rd=%h err=%b busy=%b mreq=%b we=%b addr=%h wd=%h ws=%h stray=%b",
               d, $time, g, r, rd, er, bs, mq, mw, ma, mwd, ms, st,
               e_gnt[d], e_rsp[d], e_rd[d], e_err[d], bs_e, e_mreq[d], e_we[d], e_addr[d], e_wd[d], e_ws[d], e_stray[d]);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.mem_req) mreq_cnt++;
    cmp(0, ifa.gnt, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err, ifa.busy, ifa.mem_req, ifa.mem_we,
        ifa.mem_addr, ifa.mem_wdata, ifa.mem_wstrb, ifa.err_stray);
    cmp(1, {1'b0, ifb.gnt}, {1'b0, ifb.rsp_valid}, ifb.rsp_rdata, ifb.rsp_err, ifb.busy, ifb.mem_req,
        ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.mem_wstrb, ifb.err_stray);
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] m, input int rdly, input bit give, input logic [63:0] rd,
                     output logic [2:0] ga, output logic [1:0] gb, output logic [2:0] ra,
                     output logic [1:0] rb, output logic [63:0] rda, output logic erra,
                     output logic [63:0] ma, output int wt);
    int k;
    req_m = m;
    tick();
    k = 0;
    while (ifa.gnt == 0 && k < 8) begin tick(); k++; end
    chk("gnt_seen", 64'(ifa.gnt != 0), 64'd1);
    ga = ifa.gnt; gb = ifb.gnt; ma = ifa.mem_addr;
    repeat (rdly) tick();
    mready = 1'b1; tick(); mready = 1'b0;
    wt = 0;
    if (give) begin
      mrv = 1'b1; mrdata = rd; tick(); mrv = 1'b0;
    end else begin
      while (ifa.rsp_valid == 0 && wt < 20) begin tick(); wt++; end
    end
    chk("rsp_seen", 64'(ifa.rsp_valid != 0), 64'd1);
    ra = ifa.rsp_valid; rb = ifb.rsp_valid; rda = ifa.rsp_rdata; erra = ifa.rsp_err;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0]  ga, ra;
    logic [1:0]  gb, rb;
    logic [63:0] rda, ma;
    logic        erra;
    int          wt, c0;
    logic [2:0]  rr_exp [4];
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 64'h8000_0000 + 64'(i) * 64'h1000;
      wdata[i] = 64'h1111_0000 + 64'(i);
      wstrb[i] = 8'hFF;
    end
    repeat (2) tick();
    chk("reset_busy", 64'(ifa.busy), 0);
    chk("reset_mem_req", 64'(ifa.mem_req), 0);
    chk("reset_gnt", 64'({ifa.gnt, ifb.gnt}), 0);
    rst_n = 1'b1;
    tick();

    // single read at minimum latency
    run(3'b001, 0, 1'b1, 64'h1234, ga, gb, ra, rb, rda, erra, ma, wt);
    chk("t1_gnt", 64'(ga), 64'b001);
    chk("t1_rsp", 64'(ra), 64'b001);
    chk("t1_rdata", rda, 64'h1234);
    chk("t1_err", 64'(erra), 0);
    chk("t1_addr", ma, 64'h8000_0000);

    // fixed priority keeps granting requester 0 while it holds req
    run(3'b011, 0, 1'b1, 64'hA1, ga, gb, ra, rb, rda, erra, ma, wt);
    chk("t2_fp_gnt_a", 64'(gb), 64'b01);
    run(3'b011, 0, 1'b1, 64'hA2, ga, gb, ra, rb, rda, erra, ma, wt);
    chk("t2_fp_gnt_b", 64'(gb), 64'b01);
    chk("t2_fp_rsp", 64'(rb), 64'b01);
    run(3'b010, 0, 1'b1, 64'hA3, ga, gb, ra, rb, rda, erra, ma, wt);
    chk("t2_fp_gnt_c", 64'(gb), 64'b10);
    chk("t2_fp_rsp_c", 64'(rb), 64'b10);

    // write with mem_ready delayed by three cycles
    we_m = 3'b001; wstrb[0] = 8'h0F; wdata[0] = 64'hDEAD_BEEF;
    c0 = mreq_cnt;
    run(3'b001, 3, 1'b1, 64'h0, ga, gb, ra, rb, rda, erra, ma, wt);
    chk("t4_mem_req_cycles", 64'(mreq_cnt - c0), 4);
    chk("t4_we", 64'(ifa.mem_we), 1);
    chk("t4_wstrb", 64'(ifa.mem_wstrb), 64'h0F);
    chk("t4_wdata", ifa.mem_wdata, 64'hDEAD_BEEF);
    chk("t4_rsp", 64'(ra), 64'b001);
    we_m = 3'b000;

    // silent memory: timeout error, then a stray response while idle
    run(3'b010, 0, 1'b0, 64'h0, ga, gb, ra, rb, rda, erra, ma, wt);
    req_m = 3'b000;
    chk("t5_rsp", 64'(ra), 64'b010);
    chk("t5_err", 64'(erra), 1);
    chk("t5_rdata", rda, 0);
    chk("t5_wait_cycles", 64'(wt), 5);
    chk("t5_stray_before", 64'(ifa.err_stray), 0);
    mrv = 1'b1; mrdata = 64'h55; tick(); mrv = 1'b0;
    chk("t5_stray_a", 64'(ifa.err_stray), 1);
    chk("t5_stray_b", 64'(ifb.err_stray), 1);

    // reset in the middle of WAIT
    req_m = 3'b001; tick(); req_m = 3'b000;
    mready = 1'b1; tick(); mready = 1'b0;
    tick();
    chk("t6_busy_pre", 64'(ifa.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'({ifa.busy, ifb.busy}), 0);
    chk("t6_mem_addr", ifa.mem_addr, 0);
    chk("t6_stray", 64'({ifa.err_stray, ifb.err_stray}), 0);
    mrv = 1'b1; tick(); mrv = 1'b0; tick();
    chk("t6_no_rsp", 64'({ifa.rsp_valid, ifb.rsp_valid}), 0);
    rst_n = 1'b1;
    tick();

    // round-robin rotation from a fresh pointer
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      run(3'b111, 0, 1'b1, 64'(i) + 64'h70, ga, gb, ra, rb, rda, erra, ma, wt);
      chk($sformatf("t3_rr_gnt%0d", i), 64'(ga), 64'(rr_exp[i]));
      chk($sformatf("t3_fp_gnt%0d", i), 64'(gb), 64'b01);
    end
    chk("t3_rdata_last", rda, 64'h73);
    req_m = 3'b000;
    repeat (3) tick();
    chk("end_idle", 64'({ifa.busy, ifb.busy}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
